// File: rtl/operand_loader.sv
// Operand loader for the shift-and-add multiplier: debounces one key, synchronises
// the switches, and walks the user through load M, load Q and start.
module operand_loader #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACK_TIMEOUT     = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_n,
  input  logic [7:0] sw,
  input  logic       ready,
  output logic [7:0] Qin,
  output logic       mFlag,
  output logic       start,
  output logic [2:0] phase,
  output logic       busy,
  output logic       err
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      ACK_LAST = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    LOAD_M = 3'd0,
    LOAD_Q = 3'd1,
    START  = 3'd2,
    RUN    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Two-flop synchronisers; the key idles released (high)
  logic       key_s1, key_s2;
  logic [7:0] sw_s1, sw_s2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= 8'h00;
      sw_s2  <= 8'h00;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce. 'armed' blocks a key held through reset from counting as a press
  // until it has been seen released once the synchroniser holds real samples.
  logic            key_db;
  logic [DB_W-1:0] db_cnt;
  logic [1:0]      fill;
  logic            armed;
  logic            press;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_db <= 1'b1;
      db_cnt <= '0;
      fill   <= 2'b00;
      armed  <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      fill  <= {fill[0], 1'b1};
      if (fill[1] && key_s2 && key_db) armed <= 1'b1;
      if (key_s2 == key_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt <= '0;
        key_db <= key_s2;
        press  <= armed & ~key_s2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Sequencer: all outputs are registered copies of the *_nx values
  state_t     state, state_nx;
  logic [7:0] qin_nx;
  logic [7:0] to_cnt, to_cnt_nx;
  logic       mflag_nx, start_nx, busy_nx, err_nx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= LOAD_M;
      Qin    <= 8'h00;
      mFlag  <= 1'b0;
      start  <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      to_cnt <= 8'h00;
    end else begin
      state  <= state_nx;
      Qin    <= qin_nx;
      mFlag  <= mflag_nx;
      start  <= start_nx;
      busy   <= busy_nx;
      err    <= err_nx;
      to_cnt <= to_cnt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    qin_nx    = Qin;
    mflag_nx  = 1'b0;
    start_nx  = start;
    busy_nx   = busy;
    err_nx    = err;
    to_cnt_nx = to_cnt;
    case (state)
      LOAD_M: begin
        if (press) begin
          qin_nx   = sw_s2;
          mflag_nx = 1'b1;
          state_nx = LOAD_Q;
        end
      end
      LOAD_Q: begin
        if (press) begin
          qin_nx    = sw_s2;
          start_nx  = 1'b1;
          busy_nx   = 1'b1;
          to_cnt_nx = 8'h00;
          state_nx  = START;
        end
      end
      START: begin
        // An acknowledge wins over a timeout landing on the same cycle
        if (!ready) begin
          start_nx = 1'b0;
          state_nx = RUN;
        end else if (to_cnt == ACK_LAST) begin
          start_nx = 1'b0;
          busy_nx  = 1'b0;
          err_nx   = 1'b1;
          state_nx = LOAD_M;
        end else if (to_cnt != 8'hFF) begin
          to_cnt_nx = to_cnt + 8'd1;
        end
      end
      RUN: begin
        if (ready) begin
          busy_nx  = 1'b0;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (press) state_nx = LOAD_M;
      end
      default: begin
        state_nx = LOAD_M;
        start_nx = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

  assign phase = state;

endmodule
